// File: rtl/i2s_pkg.sv
// Shared frame timing constants and FSM encodings for the microphone array
// frame scheduler.
package i2s_pkg;

  localparam int FRAME_BITS    = 64;
  localparam int BIT_W         = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] HALF_BITS = BIT_W'(32);
  localparam logic [BIT_W-1:0] SNAP_BIT  = BIT_W'(63);
  localparam int DEF_DATAWIDTH = 24;

  typedef enum logic {
    GEN_IDLE = 1'b0,
    GEN_RUN  = 1'b1
  } gen_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/i2s_ws_gen.sv
// Frame generator: 64-bit frame counter, word select and the end-of-frame
// snapshot strobe. Stopping is only honoured at the frame boundary.
module i2s_ws_gen
  import i2s_pkg::*;
(
  input  logic clk_mic,
  input  logic rst_mic_n,
  input  logic i_enable,
  output logic o_ws,
  output logic o_snap,
  output logic o_busy
);

  gen_state_t       r_state, w_state_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             r_ws;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = '0;
    case (r_state)
      GEN_IDLE: if (i_enable) w_state_nxt = GEN_RUN;
      GEN_RUN: begin
        // Counter wraps 63 -> 0 by natural overflow of the 6-bit field.
        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        if (r_bit_cnt == SNAP_BIT && !i_enable) w_state_nxt = GEN_IDLE;
      end
      default: w_state_nxt = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_state   <= GEN_IDLE;
      r_bit_cnt <= '0;
      r_ws      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      // WS follows the upcoming bit position so it is high for bits 0..31.
      r_ws      <= (w_state_nxt == GEN_RUN) && (w_bit_cnt_nxt < HALF_BITS);
    end
  end

  assign o_ws   = r_ws;
  assign o_busy = (r_state == GEN_RUN);
  assign o_snap = (r_state == GEN_RUN) && (r_bit_cnt == SNAP_BIT);

endmodule

// File: rtl/i2s_array_ctrl.sv
// Microphone array frame scheduler: snapshots every decoder's L/R sample at the
// end of each frame and streams the channels out round-robin on valid/ready.
module i2s_array_ctrl
  import i2s_pkg::*;
#(
  parameter int NUM_DEC   = 4,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CHW       = 3
)(
  input  logic                           clk_mic,
  input  logic                           rst_mic_n,
  input  logic                           enable,
  input  logic [NUM_DEC*DATAWIDTH-1:0]   dec_l_data,
  input  logic [NUM_DEC*DATAWIDTH-1:0]   dec_r_data,
  output logic                           ws_o,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATAWIDTH-1:0]           m_data,
  output logic [CHW-1:0]                 m_chan,
  output logic                           m_last,
  output logic [15:0]                    frame_cnt,
  output logic                           overrun,
  output logic                           busy
);

  localparam int NCH = 2 * NUM_DEC;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  logic                        w_snap;
  logic                        w_take;
  logic                        w_accept;
  logic [CHW-1:0]              w_ch_nxt;
  rd_state_t                   r_rd_state, w_rd_state_nxt;
  logic signed [DATAWIDTH-1:0] r_buf [NCH];
  logic signed [DATAWIDTH-1:0] r_m_data;
  logic                        r_m_valid;
  logic                        r_m_last;
  logic [CHW-1:0]              r_ch;
  logic [15:0]                 r_frame_cnt;
  logic                        r_overrun;

  i2s_ws_gen u_ws_gen (
    .clk_mic   (clk_mic),
    .rst_mic_n (rst_mic_n),
    .i_enable  (enable),
    .o_ws      (ws_o),
    .o_snap    (w_snap),
    .o_busy    (busy)
  );

  assign w_take   = w_snap && (r_rd_state == RD_IDLE);
  assign w_accept = r_m_valid && m_ready;
  assign w_ch_nxt = r_ch + CHW'(1);

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_take) w_rd_state_nxt = RD_SEND;
      RD_SEND: if (w_accept && r_ch == LAST_CH) w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Holding buffer is only ever read while RD_SEND, so it needs no reset.
  always_ff @(posedge clk_mic) begin
    if (w_take) begin
      for (int k = 0; k < NUM_DEC; k++) begin
        r_buf[2*k]   <= dec_l_data[k*DATAWIDTH +: DATAWIDTH];
        r_buf[2*k+1] <= dec_r_data[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_rd_state  <= RD_IDLE;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_ch        <= '0;
      r_m_last    <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_snap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_rd_state == RD_SEND) r_overrun <= 1'b1;
      end
      // Channel 0 is loaded straight from the decoders as the buffer fills.
      if (w_take) begin
        r_m_valid <= 1'b1;
        r_ch      <= '0;
        r_m_data  <= dec_l_data[0 +: DATAWIDTH];
        r_m_last  <= 1'b0;
      end else if (w_accept) begin
        if (r_ch == LAST_CH) begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end else begin
          r_ch     <= w_ch_nxt;
          r_m_data <= r_buf[w_ch_nxt];
          r_m_last <= (w_ch_nxt == LAST_CH);
        end
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_chan    = r_ch;
  assign m_last    = r_m_last;
  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_array_ctrl.sv
// Self-checking bench for i2s_array_ctrl: randomized decoder data and
// handshake patterns checked against a frame/queue level reference model.
module tb_i2s_array_ctrl;

  localparam int NUM_DEC = 4;
  localparam int DW      = 24;
  localparam int CHW     = 3;
  localparam int NCH     = 2 * NUM_DEC;

  logic                    clk_mic   = 1'b0;
  logic                    rst_mic_n = 1'b0;
  logic                    enable    = 1'b0;
  logic                    m_ready   = 1'b0;
  logic [NUM_DEC*DW-1:0]   dec_l_data;
  logic [NUM_DEC*DW-1:0]   dec_r_data;
  logic [DW-1:0]           dec_l [NUM_DEC];
  logic [DW-1:0]           dec_r [NUM_DEC];
  logic                    ws_o, m_valid, m_last, overrun, busy;
  logic [DW-1:0]           m_data;
  logic [CHW-1:0]          m_chan;
  logic [15:0]             frame_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_mic = ~clk_mic;

  for (genvar k = 0; k < NUM_DEC; k++) begin : g_pack
    assign dec_l_data[k*DW +: DW] = dec_l[k];
    assign dec_r_data[k*DW +: DW] = dec_r[k];
  end

  i2s_array_ctrl #(.NUM_DEC(NUM_DEC), .DATAWIDTH(DW), .CHW(CHW)) dut (
    .clk_mic    (clk_mic),
    .rst_mic_n  (rst_mic_n),
    .enable     (enable),
    .dec_l_data (dec_l_data),
    .dec_r_data (dec_r_data),
    .ws_o       (ws_o),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Reference model: frame position, a pending frame of NCH samples and a
  // read pointer into it.
  logic          mdl_run;
  int            mdl_pos;
  logic          mdl_pend;
  int            mdl_idx;
  logic [15:0]   mdl_frames;
  logic          mdl_ovr;
  logic [DW-1:0] mdl_buf [NCH];

  always @(posedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      mdl_run    <= 1'b0;
      mdl_pos    <= 0;
      mdl_pend   <= 1'b0;
      mdl_idx    <= 0;
      mdl_frames <= 16'd0;
      mdl_ovr    <= 1'b0;
    end else begin
      if (mdl_run && mdl_pos == 63) begin
        mdl_frames <= mdl_frames + 16'd1;
        if (!mdl_pend) begin
          for (int c = 0; c < NCH; c++)
            mdl_buf[c] <= (c % 2 == 0) ? dec_l[c/2] : dec_r[c/2];
          mdl_pend <= 1'b1;
          mdl_idx  <= 0;
        end else begin
          mdl_ovr <= 1'b1;
        end
      end
      if (mdl_pend && m_ready) begin
        if (mdl_idx == NCH - 1) mdl_pend <= 1'b0;
        else                    mdl_idx  <= mdl_idx + 1;
      end
      if (!mdl_run) begin
        mdl_run <= enable;
        mdl_pos <= 0;
      end else begin
        mdl_pos <= (mdl_pos + 1) % 64;
        if (mdl_pos == 63 && !enable) mdl_run <= 1'b0;
      end
    end
  end

  task automatic rand_dec();
    for (int k = 0; k < NUM_DEC; k++) begin
      dec_l[k] = DW'($urandom());
      dec_r[k] = DW'($urandom());
    end
  endtask

  task automatic pattern_dec();
    for (int k = 0; k < NUM_DEC; k++) begin
      dec_l[k] = DW'(24'h100000 + k);
      dec_r[k] = DW'(24'h200000 + k);
    end
  endtask

  task automatic test_reset();
    rst_mic_n = 1'b0;
    enable    = 1'b0;
    m_ready   = 1'b0;
    rand_dec();
    repeat (3) @(negedge clk_mic);
    nvec++;
    if ({ws_o, m_valid, m_last, overrun, busy} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_flags: ws/valid/last/ovr/busy=%b required 00000",
               {ws_o, m_valid, m_last, overrun, busy});
    end
    nvec++;
    if (m_data !== '0 || m_chan !== '0) begin
      nerr++;
      $display("FAIL reset_data: data=%h chan=%0d required 0/0", m_data, m_chan);
    end
    nvec++;
    if (frame_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    rst_mic_n = 1'b1;
    @(negedge clk_mic);
  endtask

  task automatic test_ws();
    logic exp_ws;
    pattern_dec();
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk_mic);
      exp_ws = ((n - 1) % 64) < 32;
      nvec++;
      if (ws_o !== exp_ws || busy !== 1'b1) begin
        nerr++;
        $display("FAIL ws_period n=%0d: ws=%b busy=%b required ws=%b busy=1",
                 n, ws_o, busy, exp_ws);
      end
    end
  endtask

  task automatic test_stream();
    int n;
    logic [DW-1:0] exp_pat;
    logic [15:0]   prev_fc;
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (m_valid && n < 100) begin
        if (f > 0) rand_dec();
        @(negedge clk_mic);
        n++;
      end
      n = 0;
      while (!m_valid && n < 100) begin
        if (f > 0) rand_dec();
        @(negedge clk_mic);
        n++;
      end
      nvec++;
      if (m_valid !== 1'b1) begin
        nerr++;
        $display("FAIL stream_start f=%0d: m_valid=%b required 1 within 100 cycles", f, m_valid);
      end
      prev_fc = mdl_frames - 16'd1;
      for (int c = 0; c < NCH; c++) begin
        nvec++;
        if (m_valid !== 1'b1 || m_chan !== CHW'(c) || m_data !== mdl_buf[c] ||
            m_last !== (c == NCH - 1)) begin
          nerr++;
          $display("FAIL stream_beat f=%0d c=%0d: v=%b chan=%0d data=%h last=%b required 1/%0d/%h/%b",
                   f, c, m_valid, m_chan, m_data, m_last, c, mdl_buf[c], (c == NCH - 1));
        end
        if (f == 0) begin
          exp_pat = (c % 2 == 0) ? DW'(24'h100000 + c/2) : DW'(24'h200000 + c/2);
          nvec++;
          if (m_data !== exp_pat) begin
            nerr++;
            $display("FAIL stream_pattern c=%0d: data=%h required %h", c, m_data, exp_pat);
          end
        end
        rand_dec();
        @(negedge clk_mic);
      end
      nvec++;
      if (m_valid !== 1'b0 || frame_cnt !== mdl_frames || frame_cnt !== prev_fc + 16'd1) begin
        nerr++;
        $display("FAIL stream_end f=%0d: valid=%b frame_cnt=%0d required 0/%0d",
                 f, m_valid, frame_cnt, prev_fc + 16'd1);
      end
    end
  endtask

  task automatic test_toggle();
    int n, beats;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [CHW-1:0] prev_chan;
    m_ready = 1'b1;
    n = 0;
    while (m_valid && n < 100) begin @(negedge clk_mic); n++; end
    n = 0;
    while (!m_valid && n < 100) begin rand_dec(); @(negedge clk_mic); n++; end
    beats = 0;
    prev_stall = 1'b0;
    m_ready = 1'b0;
    n = 0;
    while (beats < NCH && n < 40) begin
      nvec++;
      if (m_valid !== mdl_pend ||
          (mdl_pend && (m_data !== mdl_buf[mdl_idx] || m_chan !== CHW'(mdl_idx) ||
                        m_last !== (mdl_idx == NCH - 1)))) begin
        nerr++;
        $display("FAIL toggle_beat: v=%b chan=%0d data=%h required v=%b chan=%0d data=%h",
                 m_valid, m_chan, m_data, mdl_pend, mdl_idx, mdl_buf[mdl_idx]);
      end
      if (prev_stall) begin
        nvec++;
        if (m_data !== prev_data || m_chan !== prev_chan) begin
          nerr++;
          $display("FAIL toggle_hold: data=%h chan=%0d required %h/%0d",
                   m_data, m_chan, prev_data, prev_chan);
        end
      end
      m_ready = ~m_ready;
      if (m_valid && m_ready) beats++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_chan  = m_chan;
      rand_dec();
      @(negedge clk_mic);
      n++;
    end
    nvec++;
    if (beats != NCH || overrun !== 1'b0) begin
      nerr++;
      $display("FAIL toggle_total: beats=%0d overrun=%b required %0d/0", beats, overrun, NCH);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_overrun();
    int n;
    rst_mic_n = 1'b0;
    m_ready   = 1'b0;
    enable    = 1'b0;
    @(negedge clk_mic);
    rst_mic_n = 1'b1;
    enable    = 1'b1;
    n = 0;
    while (!m_valid && n < 100) begin rand_dec(); @(negedge clk_mic); n++; end
    nvec++;
    if (m_valid !== 1'b1 || frame_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL ovr_first: valid=%b frame_cnt=%0d required 1/1", m_valid, frame_cnt);
    end
    for (int i = 0; i < 70; i++) begin
      nvec++;
      if (m_valid !== 1'b1 || m_chan !== '0 || m_data !== mdl_buf[0]) begin
        nerr++;
        $display("FAIL ovr_stall i=%0d: v=%b chan=%0d data=%h required 1/0/%h",
                 i, m_valid, m_chan, m_data, mdl_buf[0]);
      end
      rand_dec();
      @(negedge clk_mic);
    end
    nvec++;
    if (overrun !== 1'b1 || frame_cnt !== 16'd2 || frame_cnt !== mdl_frames) begin
      nerr++;
      $display("FAIL ovr_flag: overrun=%b frame_cnt=%0d required 1/2", overrun, frame_cnt);
    end
    m_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      nvec++;
      if (m_valid !== 1'b1 || m_chan !== CHW'(c) || m_data !== mdl_buf[c]) begin
        nerr++;
        $display("FAIL ovr_drain c=%0d: v=%b chan=%0d data=%h required 1/%0d/%h",
                 c, m_valid, m_chan, m_data, c, mdl_buf[c]);
      end
      rand_dec();
      @(negedge clk_mic);
    end
    nvec++;
    if (m_valid !== 1'b0 || overrun !== 1'b1) begin
      nerr++;
      $display("FAIL ovr_after: valid=%b overrun=%b required 0/1", m_valid, overrun);
    end
  endtask

  task automatic test_disable();
    int n;
    logic [15:0] base_fc;
    logic exp_ws, exp_busy;
    m_ready = 1'b1;
    n = 0;
    while (!(mdl_run && mdl_pos == 10) && n < 100) begin @(negedge clk_mic); n++; end
    nvec++;
    if (!(mdl_run && mdl_pos == 10)) begin
      nerr++;
      $display("FAIL dis_sync: did not reach bit 10 within 100 cycles (run=%b pos=%0d)",
               mdl_run, mdl_pos);
    end
    base_fc = mdl_frames;
    enable  = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_mic);
      exp_busy = (10 + i) <= 63;
      exp_ws   = exp_busy && ((10 + i) < 32);
      nvec++;
      if (ws_o !== exp_ws || busy !== exp_busy) begin
        nerr++;
        $display("FAIL dis_run i=%0d: ws=%b busy=%b required %b/%b",
                 i, ws_o, busy, exp_ws, exp_busy);
      end
    end
    nvec++;
    if (frame_cnt !== base_fc + 16'd1) begin
      nerr++;
      $display("FAIL dis_snap: frame_cnt=%0d required %0d", frame_cnt, base_fc + 16'd1);
    end
    repeat (40) @(negedge clk_mic);
    nvec++;
    if (ws_o !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      nerr++;
      $display("FAIL dis_idle: ws=%b busy=%b valid=%b required 0/0/0", ws_o, busy, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    m_ready = 1'b1;
    enable  = 1'b1;
    n = 0;
    while (!(m_valid && m_chan == 3) && n < 200) begin rand_dec(); @(negedge clk_mic); n++; end
    nvec++;
    if (!(m_valid && m_chan == 3)) begin
      nerr++;
      $display("FAIL rmid_wait: chan 3 not seen within 200 cycles (v=%b chan=%0d)", m_valid, m_chan);
    end
    #2 rst_mic_n = 1'b0;
    #1;
    nvec++;
    if ({ws_o, m_valid, m_last, overrun, busy} !== 5'b0 || m_data !== '0 ||
        m_chan !== '0 || frame_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL rmid_async: ws/v/last/ovr/busy=%b data=%h chan=%0d fc=%0d required all 0",
               {ws_o, m_valid, m_last, overrun, busy}, m_data, m_chan, frame_cnt);
    end
    enable = 1'b0;
    @(negedge clk_mic);
    rst_mic_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_mic);
      if (m_valid || busy) seen = 1'b1;
    end
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL rmid_quiet: valid/busy seen=%b required 0 while disabled", seen);
    end
    enable = 1'b1;
    n = 0;
    while (!m_valid && n < 100) begin @(negedge clk_mic); n++; end
    nvec++;
    if (m_valid !== 1'b1 || m_chan !== '0 || m_data !== mdl_buf[0] || frame_cnt !== 16'd1 ||
        n != 65) begin
      nerr++;
      $display("FAIL rmid_restart: v=%b chan=%0d data=%h fc=%0d cycles=%0d required 1/0/%h/1/65",
               m_valid, m_chan, m_data, frame_cnt, n, mdl_buf[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ws();
    test_stream();
    test_toggle();
    test_overrun();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2s_array_ctrl.md
Name: i2s_array_ctrl

Overview:
Frame scheduler for the microphone array. Generates the shared WS for all i2s_decoder instances on clk_mic, at 64 clk_mic per frame. Snapshots every decoder's L/R sample at a fixed frame slot. Shares a single valid/ready output stream among all channels, in fixed round-robin order, feeding the beamforming/FIFO path.

Parameters:
NUM_DEC, 4, number of i2s_decoder instances (one stereo mic pair each); channels NCH = 2*NUM_DEC, max 32
DATAWIDTH, 24, sample width, signed two's complement
CHW, 3, channel-index width, = clog2(NCH)

Ports:
clk_mic  in  1  I2S bit clock, 64*fs; all logic on its rising edge
rst_mic_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled at frame boundary
dec_l_data  in  NUM_DEC*DATAWIDTH  packed L_DATA of decoders; dec k at [k*DATAWIDTH +: DATAWIDTH]
dec_r_data  in  NUM_DEC*DATAWIDTH  packed R_DATA of decoders, same packing
ws_o  out  1  word select to mics and decoders; 1 = right half, 0 = left half
m_valid  out  1  output sample valid
m_ready  in  1  downstream accept
m_data  out  DATAWIDTH  sample
m_chan  out  CHW  channel index: 2k = dec k left, 2k+1 = dec k right
m_last  out  1  high with the last channel (NCH-1) of a frame
frame_cnt  out  16  frames snapshotted, wraps 0xFFFF->0
overrun  out  1  sticky; a snapshot was dropped
busy  out  1  frame generator running

Behaviour:
- Reset values: ws_o=0, m_valid=0, m_data=0, m_chan=0, m_last=0, frame_cnt=0, overrun=0, busy=0. Internally bit_cnt=0, generator in IDLE, readout in RD_IDLE.
- Generator FSM:
  - IDLE: bit_cnt held 0, ws_o=0. enable=1 -> RUN next cycle, busy=1.
  - RUN: bit_cnt increments 0..63 and wraps.
  - ws_o = 1 for bit_cnt 0..31 and 0 for 32..63, registered. The first RUN cycle therefore gives a WS rising edge that starts the decoders' right phase.
  - At bit_cnt==63: if enable=0 -> IDLE. Stopping occurs only at a frame boundary; the frame in progress completes.
- Snapshot strobe snap = RUN && bit_cnt==63. Both halves' data are then complete: right done by bit 25, left by bit 57.
- On snap with readout in RD_IDLE:
  - copy all 2*NUM_DEC samples into the holding buffer (NCH x DATAWIDTH regs);
  - frame_cnt += 1;
  - readout -> RD_SEND starting at channel 0.
- On snap with readout in RD_SEND: buffer is not overwritten, overrun<=1 (sticky until reset), frame_cnt still increments.
- Readout FSM:
  - RD_SEND: m_valid=1; m_data=buf[ch], m_chan=ch, m_last=(ch==NCH-1).
  - On each cycle with m_valid&&m_ready, ch advances; after NCH-1 is accepted -> RD_IDLE, m_valid=0 next cycle.
  - Outputs are registered; first m_valid rises the cycle after snap.
  - m_data/m_chan remain stable while m_valid&&!m_ready (AXI-stream rule).
- Back-to-back transfers are 1 per cycle. With m_ready=1 a frame drains in NCH cycles, well under 64.
- enable deasserted mid-frame: generator stops after bit 63. A readout in progress still completes.
- Async reset mid-operation clears everything immediately, including the buffer contents' validity. Any partial frame is discarded.
- Decoder inputs are same-domain (posedge clk_mic) registers; no synchroniser.

Decomposition:
- Package i2s_pkg: FRAME_BITS=64, HALF_BITS=32, SNAP_BIT=63, DATAWIDTH default, generator and readout state encodings.
- One sub-module, i2s_ws_gen: bit counter, ws_o, snap, busy, enable handling.
- Readout buffer and FSM stay in the top.

Test Plan:
- Reset then enable=1: ws_o rises 1 cycle after enable, is high 32 cycles and low 32, period 64; busy=1.
- dec k L=0x100000+k, R=0x200000+k, m_ready=1: after each snap, 8 consecutive beats.
  - Order: chan 0..7 with data 0x100000, 0x200000, 0x100001, ...
  - m_last only on chan 7; frame_cnt increments by 1.
- m_ready toggles 1/0 every cycle: each beat holds data and chan while stalled; all 8 beats delivered; overrun stays 0.
- m_ready=0 for 70 cycles after a snap: second snap is dropped, overrun=1, frame_cnt=2. Buffer still shows frame-1 values when m_ready returns.
- enable=0 at bit_cnt 10: frame continues to bit 63, snap occurs, then IDLE with ws_o=0 and busy=0.
- rst_mic_n pulsed low mid-readout at chan 3: all outputs return to reset values immediately; no beats until the next enable and snap.
